fifo_dac_scheduler: RTL and testbench
=====================================

FIFO_DAC_SCHEDULER -- requirements
Module: fifo_dac_scheduler

Interface
REQ-001 SHALL have parameter DIV_W, default 26, width of the sample-period divider.
REQ-002 SHALL have parameter DATA_W, default 8, DAC sample width.
REQ-003 SHALL have parameter CNT_W, default 16, underrun counter width.
REQ-004 SHALL have parameter IDLE_CODE, default 8'h80, DAC output code when idle or muted.
REQ-005 SHALL have port CLK  in  1  single clock (48 MHz IFCLK domain); all logic on rising edge.
REQ-006 SHALL have port RST  in  1  synchronous, active-high reset.
REQ-007 SHALL have port EN  in  1  playback enable from a PIO bit.
REQ-008 SHALL have port DIV  in  DIV_W  sample period in CLK cycles.
REQ-009 SHALL have port UR_MODE  in  1  underrun output policy: 0 = hold last sample, 1 = output IDLE_CODE.
REQ-010 SHALL have port CLR_CNT  in  1  single-cycle clear of UR_CNT.
REQ-011 SHALL have port FLAG_NE  in  1  FX2 FIFO not-empty flag, active-high, already synchronous to CLK.
REQ-012 SHALL have port FD_IN  in  DATA_W  FX2 FIFO data bus.
REQ-013 SHALL have port SLRDN  out  1  FX2 slave-FIFO read strobe, active-low.
REQ-014 SHALL have port DAC_DATA  out  DATA_W  registered DAC code.
REQ-015 SHALL have port SAMPLE_STB  out  1  one-cycle pulse when DAC_DATA is updated from the FIFO.
REQ-016 SHALL have port UR_CNT  out  CNT_W  saturating underrun count.
REQ-017 SHALL have port STATE  out  2  current FSM state code.

Function
REQ-018 SHALL treat an effective period P = max(DIV, 1).
REQ-019 SHALL run a phase counter 0..P-1 only in RUN/UNDER; tick = (counter == 0).
REQ-020 SHALL hold the counter at 0 in IDLE and PRIME.
REQ-021 SHALL wrap the counter to 0 on the next cycle if DIV is lowered so that the counter is >= P-1.
REQ-022 SHALL implement states IDLE=0, PRIME=1, RUN=2, UNDER=3.
REQ-023 SHALL transition IDLE->PRIME when EN=1.
REQ-024 SHALL transition PRIME->RUN when FLAG_NE=1, so the first tick occurs in the first RUN cycle.
REQ-025 SHALL transition RUN->UNDER on a tick with FLAG_NE=0.
REQ-026 SHALL transition UNDER->RUN on a tick with FLAG_NE=1.
REQ-027 SHALL transition any state->IDLE on the cycle after EN=0; EN=0 takes priority over all other transitions.
REQ-028 SHALL drive SLRDN low (combinationally) only when EN=1, state is RUN or UNDER, tick=1 and FLAG_NE=1; otherwise high. Never low for two consecutive cycles unless P=1.
REQ-029 SHALL capture FD_IN into DAC_DATA at the rising edge ending each SLRDN-low cycle and pulse SAMPLE_STB in the following cycle (latency 1).
REQ-030 SHALL, on a tick with FLAG_NE=0 in RUN or UNDER, increment UR_CNT, saturating at all-ones.
REQ-031 SHALL, in that same case, hold DAC_DATA if UR_MODE=0, or load IDLE_CODE if UR_MODE=1.
REQ-032 SHALL give CLR_CNT priority over a simultaneous increment (result 0).
REQ-033 SHALL load DAC_DATA with IDLE_CODE on entry to IDLE.
REQ-034 SHALL generate no read and no underrun count in IDLE or PRIME.

Reset
REQ-035 SHALL, on RST=1, set state to IDLE, counter to 0, DAC_DATA to IDLE_CODE, SAMPLE_STB to 0, UR_CNT to 0, and SLRDN high in the same cycle.
REQ-036 SHALL give RST priority over EN, CLR_CNT and all transitions; reset mid-RUN aborts with no further SLRDN low.

Structure
REQ-037 SHALL take the state encodings and IDLE_CODE default from a shared package, fifo_dac_pkg.
REQ-038 SHALL place the phase counter and tick generation in one sub-module, rate_tick_gen, leaving the FSM and datapath in the top.

Verification
REQ-039 SHALL verify: DIV=4, EN=1, FLAG_NE=1, FD_IN incrementing -> SLRDN low 1 cycle in every 4, DAC_DATA steps each 4 cycles, latency 1.
REQ-040 SHALL verify: DIV=0 -> behaves as DIV=1, SLRDN low continuously, new sample every cycle.
REQ-041 SHALL verify: DIV=10, FLAG_NE dropped for 25 cycles, UR_MODE=0 -> UR_CNT=3, DAC_DATA held, state UNDER, returns to RUN on next tick with FLAG_NE=1.
REQ-042 SHALL verify: the same as REQ-041 with UR_MODE=1 -> DAC_DATA=8'h80 during underrun.
REQ-043 SHALL verify: CLR_CNT coincident with an underrun tick -> UR_CNT=0; UR_CNT at 16'hFFFF plus one underrun -> stays 16'hFFFF.
REQ-044 SHALL verify: RST asserted mid-RUN, or EN=0 -> SLRDN high the same or next cycle respectively, state IDLE, DAC_DATA=8'h80; with EN=1 and FLAG_NE=0 -> stays in PRIME with no reads.

Source files
------------

// File: rtl/fifo_dac_pkg.sv
// Shared definitions for the FX2 FIFO to DAC sample scheduler.
package fifo_dac_pkg;

    localparam int unsigned STATE_W = 2;
    localparam logic [7:0]  IDLE_CODE_DEFAULT = 8'h80;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE  = 2'd0,
        ST_PRIME = 2'd1,
        ST_RUN   = 2'd2,
        ST_UNDER = 2'd3
    } state_e;

    // Playback states in which the sample clock runs.
    function automatic logic is_playing(state_e s);
        return (s == ST_RUN) || (s == ST_UNDER);
    endfunction

endpackage

// File: rtl/rate_tick_gen.sv
// Sample-period phase counter; tick_c marks phase 0 while the clock is enabled.
module rate_tick_gen #(
    parameter int unsigned DIV_W = 26
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             active,
    input  logic [DIV_W-1:0] div,
    output logic             tick_c
);

    logic [DIV_W-1:0] cnt_q;
    logic [DIV_W-1:0] cnt_d;
    logic [DIV_W-1:0] last;

    // A period of 0 behaves as 1; wrapping on >= also catches a lowered divider.
    always_comb begin
        last  = (div == '0) ? '0 : div - DIV_W'(1);
        cnt_d = cnt_q;
        if (!active) begin
            cnt_d = '0;
        end else if (cnt_q >= last) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + DIV_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick_c = active && (cnt_q == '0);

endmodule

// File: rtl/fifo_dac_scheduler.sv
// Paces reads from the FX2 slave FIFO into a DAC register, tracking underruns.
module fifo_dac_scheduler
    import fifo_dac_pkg::*;
#(
    parameter int unsigned       DIV_W     = 26,
    parameter int unsigned       DATA_W    = 8,
    parameter int unsigned       CNT_W     = 16,
    parameter logic [DATA_W-1:0] IDLE_CODE = DATA_W'(IDLE_CODE_DEFAULT)
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              EN,
    input  logic [DIV_W-1:0]  DIV,
    input  logic              UR_MODE,
    input  logic              CLR_CNT,
    input  logic              FLAG_NE,
    input  logic [DATA_W-1:0] FD_IN,
    output logic              SLRDN,
    output logic [DATA_W-1:0] DAC_DATA,
    output logic              SAMPLE_STB,
    output logic [CNT_W-1:0]  UR_CNT,
    output logic [1:0]        STATE
);

    state_e              state_q;
    state_e              state_d;
    logic                active;
    logic                tick;
    logic                rd;
    logic                ur;
    logic [DATA_W-1:0]   dac_q;
    logic [DATA_W-1:0]   dac_d;
    logic                stb_q;
    logic                stb_d;
    logic [CNT_W-1:0]    ur_cnt_q;
    logic [CNT_W-1:0]    ur_cnt_d;

    // Dropping EN stops the sample clock immediately, so no read or count on abort.
    assign active = EN && is_playing(state_q);

    rate_tick_gen #(
        .DIV_W (DIV_W)
    ) u_rate_tick_gen (
        .clk    (CLK),
        .rst    (RST),
        .active (active),
        .div    (DIV),
        .tick_c (tick)
    );

    assign rd = tick && FLAG_NE && !RST;
    assign ur = tick && !FLAG_NE;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (!EN) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE:  state_d = ST_PRIME;
                ST_PRIME: if (FLAG_NE) state_d = ST_RUN;
                ST_RUN:   if (ur) state_d = ST_UNDER;
                ST_UNDER: if (tick && FLAG_NE) state_d = ST_RUN;
                default:  state_d = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        SLRDN    = !rd;
        stb_d    = rd;
        dac_d    = dac_q;
        ur_cnt_d = ur_cnt_q;
        if (!EN) begin
            dac_d = IDLE_CODE;
        end else if (rd) begin
            dac_d = FD_IN;
        end else if (ur && UR_MODE) begin
            dac_d = IDLE_CODE;
        end
        if (CLR_CNT) begin
            ur_cnt_d = '0;
        end else if (ur && !(&ur_cnt_q)) begin
            ur_cnt_d = ur_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            dac_q    <= IDLE_CODE;
            stb_q    <= 1'b0;
            ur_cnt_q <= '0;
        end else begin
            dac_q    <= dac_d;
            stb_q    <= stb_d;
            ur_cnt_q <= ur_cnt_d;
        end
    end

    assign DAC_DATA   = dac_q;
    assign SAMPLE_STB = stb_q;
    assign UR_CNT     = ur_cnt_q;
    assign STATE      = state_q;

endmodule

// File: tb/tb_fifo_dac_scheduler.sv
// Randomized scoreboard bench for fifo_dac_scheduler against a behavioural model.
module tb_fifo_dac_scheduler;

    localparam int DIV_W  = 26;
    localparam int DATA_W = 8;
    localparam int CNT_W  = 16;

    logic              CLK = 1'b0;
    logic              RST;
    logic              EN;
    logic [DIV_W-1:0]  DIV;
    logic              UR_MODE;
    logic              CLR_CNT;
    logic              FLAG_NE;
    logic [DATA_W-1:0] FD_IN;
    logic              SLRDN;
    logic [DATA_W-1:0] DAC_DATA;
    logic              SAMPLE_STB;
    logic [CNT_W-1:0]  UR_CNT;
    logic [1:0]        STATE;

    fifo_dac_scheduler #(
        .DIV_W  (DIV_W),
        .DATA_W (DATA_W),
        .CNT_W  (CNT_W)
    ) dut (
        .CLK        (CLK),
        .RST        (RST),
        .EN         (EN),
        .DIV        (DIV),
        .UR_MODE    (UR_MODE),
        .CLR_CNT    (CLR_CNT),
        .FLAG_NE    (FLAG_NE),
        .FD_IN      (FD_IN),
        .SLRDN      (SLRDN),
        .DAC_DATA   (DAC_DATA),
        .SAMPLE_STB (SAMPLE_STB),
        .UR_CNT     (UR_CNT),
        .STATE      (STATE)
    );

    always #5 CLK = ~CLK;

    int checks   = 0;
    int failures = 0;
    int lows     = 0;
    bit fd_incr  = 1'b0;

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: states 0 idle, 1 prime, 2 run, 3 under.
    int          m_state = 0;
    int          m_phase = 0;
    int unsigned m_ur    = 0;
    int          m_dac   = 'h80;
    bit          m_stb   = 1'b0;
    logic [DATA_W-1:0] last_read = '0;
    logic [DATA_W-1:0] exp_q[$];
    logic m_tick, m_rd, m_ur_ev;

    function automatic int period();
        return (DIV == 0) ? 1 : int'(DIV);
    endfunction

    always_comb begin
        m_tick  = EN && (m_state >= 2) && (m_phase == 0);
        m_rd    = m_tick && FLAG_NE && !RST;
        m_ur_ev = m_tick && !FLAG_NE;
    end

    always @(posedge CLK) begin
        if (RST) begin
            m_state <= 0;
            m_phase <= 0;
            m_dac   <= 'h80;
            m_stb   <= 1'b0;
            m_ur    <= 0;
        end else begin
            m_stb <= m_rd;
            if (m_rd) begin
                exp_q.push_back(FD_IN);
                last_read <= FD_IN;
            end
            if (CLR_CNT) m_ur <= 0;
            else if (m_ur_ev && m_ur < 65535) m_ur <= m_ur + 1;
            if (!EN) m_dac <= 'h80;
            else if (m_rd) m_dac <= int'(FD_IN);
            else if (m_ur_ev && UR_MODE) m_dac <= 'h80;
            if (EN && m_state >= 2) m_phase <= (m_phase >= period() - 1) ? 0 : m_phase + 1;
            else m_phase <= 0;
            if (!EN) m_state <= 0;
            else if (m_state == 0) m_state <= 1;
            else if (m_state == 1 && FLAG_NE) m_state <= 2;
            else if (m_state == 2 && m_ur_ev) m_state <= 3;
            else if (m_state == 3 && m_tick && FLAG_NE) m_state <= 2;
        end
    end

    // Per-cycle comparison of every output against the model.
    always @(negedge CLK) begin
        check("slrdn", 64'(SLRDN), 64'(!m_rd));
        check("state", 64'(STATE), 64'(m_state[1:0]));
        check("dac_data", 64'(DAC_DATA), 64'(m_dac[7:0]));
        check("ur_cnt", 64'(UR_CNT), 64'(m_ur));
        check("sample_stb", 64'(SAMPLE_STB), 64'(m_stb));
        if (SLRDN === 1'b0) lows++;
    end

    // Scoreboard monitor: every strobe must present the next expected sample.
    always @(negedge CLK) begin
        if (SAMPLE_STB === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL sample_unexpected actual=%0h required=none", DAC_DATA);
            end else begin
                check("sample", 64'(DAC_DATA), 64'(exp_q.pop_front()));
            end
        end
    end

    task automatic step(int n);
        repeat (n) begin
            @(posedge CLK);
            #1;
            if (fd_incr) FD_IN = FD_IN + 8'd1;
            else FD_IN = DATA_W'($urandom);
        end
    endtask

    task automatic underrun_scenario(bit mode);
        EN = 1'b0;
        step(2);
        CLR_CNT = 1'b1;
        step(1);
        CLR_CNT = 1'b0;
        DIV = DIV_W'(10);
        UR_MODE = mode;
        FLAG_NE = 1'b1;
        EN = 1'b1;
        step(12);
        FLAG_NE = 1'b0;
        step(25);
        check("ur_cnt_after_25", 64'(UR_CNT), 64'd3);
        check("ur_state_under", 64'(STATE), 64'd3);
        check("ur_dac", 64'(DAC_DATA), mode ? 64'h80 : 64'(last_read));
        FLAG_NE = 1'b1;
        step(5);
        check("ur_still_under", 64'(STATE), 64'd3);
        step(1);
        check("ur_back_to_run", 64'(STATE), 64'd2);
    endtask

    initial begin
        RST = 1'b1; EN = 1'b1; DIV = DIV_W'(4); UR_MODE = 1'b0;
        CLR_CNT = 1'b0; FLAG_NE = 1'b1; FD_IN = '0;
        step(3);
        check("rst_state", 64'(STATE), 64'd0);
        check("rst_dac", 64'(DAC_DATA), 64'h80);
        check("rst_ur_cnt", 64'(UR_CNT), 64'd0);
        check("rst_stb", 64'(SAMPLE_STB), 64'd0);
        check("rst_slrdn", 64'(SLRDN), 64'd1);

        // DIV=4 with incrementing data.
        RST = 1'b0; EN = 1'b0; fd_incr = 1'b1;
        step(2);
        EN = 1'b1;
        step(2);
        lows = 0;
        step(40);
        check("div4_reads", 64'(lows), 64'd10);

        // DIV=0 behaves as 1.
        DIV = '0;
        step(2);
        lows = 0;
        step(20);
        check("div0_reads", 64'(lows), 64'd20);
        fd_incr = 1'b0;

        underrun_scenario(1'b0);
        underrun_scenario(1'b1);

        // Clear coincident with an underrun tick.
        DIV = DIV_W'(1); FLAG_NE = 1'b0;
        step(3);
        CLR_CNT = 1'b1;
        step(1);
        CLR_CNT = 1'b0;
        check("clr_priority", 64'(UR_CNT), 64'd0);

        // Saturation.
        DIV = '0;
        step(65540);
        check("ur_saturate", 64'(UR_CNT), 64'hFFFF);
        step(1);
        check("ur_saturate_hold", 64'(UR_CNT), 64'hFFFF);

        // Reset mid-RUN.
        FLAG_NE = 1'b1;
        step(3);
        check("pre_rst_run", 64'(STATE), 64'd2);
        RST = 1'b1;
        #1 check("rst_slrdn_same_cycle", 64'(SLRDN), 64'd1);
        step(1);
        check("rst_mid_state", 64'(STATE), 64'd0);
        check("rst_mid_dac", 64'(DAC_DATA), 64'h80);
        RST = 1'b0;

        // EN=0 mid-RUN.
        step(4);
        check("pre_en0_run", 64'(STATE), 64'd2);
        EN = 1'b0;
        #1 check("en0_slrdn", 64'(SLRDN), 64'd1);
        step(1);
        check("en0_state", 64'(STATE), 64'd0);
        check("en0_dac", 64'(DAC_DATA), 64'h80);

        // Stuck in PRIME while FIFO empty.
        FLAG_NE = 1'b0; EN = 1'b1;
        step(2);
        lows = 0;
        step(20);
        check("prime_no_reads", 64'(lows), 64'd0);
        check("prime_state", 64'(STATE), 64'd1);
        check("prime_ur_cnt", 64'(UR_CNT), 64'd0);

        // Divider lowered below the current phase.
        FLAG_NE = 1'b1; DIV = DIV_W'(20);
        step(17);
        DIV = DIV_W'(5);
        step(12);

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            if (i % 50 == 0) begin
                DIV = DIV_W'($urandom_range(0, 6));
                UR_MODE = 1'($urandom_range(0, 1));
            end
            EN      = ($urandom_range(0, 49) != 0);
            FLAG_NE = ($urandom_range(0, 3) != 0);
            CLR_CNT = ($urandom_range(0, 99) == 0);
            RST     = ($urandom_range(0, 299) == 0);
            step(1);
        end

        RST = 1'b0; EN = 1'b0; CLR_CNT = 1'b0;
        step(5);
        check("exp_queue_drained", 64'(exp_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
